// File: rtl/one_idx_scheduler_if.sv
// Handshake bundle between a mask producer / index consumer and one_idx_scheduler.
interface one_idx_scheduler_if #(parameter int IDX_W = 7);
  logic                  i_clear;
  logic                  i_in_valid;
  logic [2**IDX_W-1:0]   i_in_data;
  logic                  o_in_ready;
  logic                  o_out_valid;
  logic [IDX_W-1:0]      o_out_idx;
  logic                  o_out_last;
  logic                  i_out_ready;
  logic                  o_done;
  logic [7:0]            o_total;

  modport slave (
    input  i_clear, i_in_valid, i_in_data, i_out_ready,
    output o_in_ready, o_out_valid, o_out_idx, o_out_last, o_done, o_total
  );

  modport master (
    output i_clear, i_in_valid, i_in_data, i_out_ready,
    input  o_in_ready, o_out_valid, o_out_idx, o_out_last, o_done, o_total
  );
endinterface

// File: rtl/one_idx_scheduler.sv
// Walks the set bits of a mask lowest-first, handing out one index per cycle
// from a 4-deep buffer that is refilled from a find-first-four search.

module find_1_idx #(parameter int IDX_W = 7) (
  input  logic [2**IDX_W-1:0] i_mask,
  output logic [IDX_W-1:0]    o_idx1,
  output logic [IDX_W-1:0]    o_idx2,
  output logic [IDX_W-1:0]    o_idx3,
  output logic [IDX_W-1:0]    o_idx4,
  output logic [2:0]          o_num_found
);
  localparam int W = 2**IDX_W;

  // Priority search for the four lowest set bits.
  always_comb begin
    logic [2:0] n;
    n      = 3'd0;
    o_idx1 = {IDX_W{1'b0}};
    o_idx2 = {IDX_W{1'b0}};
    o_idx3 = {IDX_W{1'b0}};
    o_idx4 = {IDX_W{1'b0}};
    for (int k = 0; k < W; k++) begin
      if (i_mask[k] && (n < 3'd4)) begin
        case (n)
          3'd0:    o_idx1 = IDX_W'(k);
          3'd1:    o_idx2 = IDX_W'(k);
          3'd2:    o_idx3 = IDX_W'(k);
          3'd3:    o_idx4 = IDX_W'(k);
          default: o_idx4 = o_idx4;
        endcase
        n = n + 3'd1;
      end else begin
        n = n;
      end
    end
    o_num_found = n;
  end
endmodule

module one_idx_scheduler #(parameter int IDX_W = 7) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  one_idx_scheduler_if.slave   bus
);
  localparam int W = 2**IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [W-1:0]        mask_r, mask_s, clr_s;
  logic [IDX_W-1:0]    ibuf_r [4];
  logic [IDX_W-1:0]    ibuf_s [4];
  logic [IDX_W-1:0]    found_s [4];
  logic [2:0]          cnt_r, cnt_s, num_s;
  logic [7:0]          total_r, total_s;
  logic                valid_s, pop_s, refill_s, accept_s;

  find_1_idx #(.IDX_W(IDX_W)) u_find (
    .i_mask      (mask_r),
    .o_idx1      (found_s[0]),
    .o_idx2      (found_s[1]),
    .o_idx3      (found_s[2]),
    .o_idx4      (found_s[3]),
    .o_num_found (num_s)
  );

  assign valid_s  = (cnt_r != 3'd0);
  assign pop_s    = valid_s && bus.i_out_ready;
  assign accept_s = (state_r == IDLE) && bus.i_in_valid;
  assign refill_s = (state_r == SCAN) && ((cnt_r == 3'd0) || ((cnt_r == 3'd1) && pop_s));

  // Bits about to be moved from the mask into the buffer.
  always_comb begin
    clr_s = {W{1'b0}};
    for (int j = 0; j < 4; j++) begin
      clr_s = clr_s | ((3'(j) < num_s) ? (W'(1) << found_s[j]) : {W{1'b0}});
    end
  end

  // Next-state and datapath update; i_clear overrides everything else.
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    cnt_s   = cnt_r;
    total_s = total_r;
    for (int j = 0; j < 4; j++) ibuf_s[j] = ibuf_r[j];
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          mask_s  = bus.i_in_data;
          cnt_s   = 3'd0;
          total_s = 8'd0;
          for (int j = 0; j < 4; j++) ibuf_s[j] = {IDX_W{1'b0}};
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (pop_s) total_s = total_r + 8'd1;
        else       total_s = total_r;
        if (refill_s) begin
          for (int j = 0; j < 4; j++) ibuf_s[j] = found_s[j];
          cnt_s  = num_s;
          mask_s = mask_r & ~clr_s;
        end else if (pop_s) begin
          ibuf_s[0] = ibuf_r[1];
          ibuf_s[1] = ibuf_r[2];
          ibuf_s[2] = ibuf_r[3];
          ibuf_s[3] = {IDX_W{1'b0}};
          cnt_s     = cnt_r - 3'd1;
        end else begin
          cnt_s = cnt_r;
        end
        // Covers both the empty-mask case and popping the final index.
        if (refill_s && (mask_r == {W{1'b0}})) state_s = DONE;
        else                                   state_s = SCAN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (bus.i_clear) begin
      state_s = IDLE;
      mask_s  = {W{1'b0}};
      cnt_s   = 3'd0;
      total_s = 8'd0;
    end else begin
      state_s = state_s;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      mask_r  <= {W{1'b0}};
      cnt_r   <= 3'd0;
      total_r <= 8'd0;
      for (int j = 0; j < 4; j++) ibuf_r[j] <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      mask_r  <= mask_s;
      cnt_r   <= cnt_s;
      total_r <= total_s;
      for (int j = 0; j < 4; j++) ibuf_r[j] <= ibuf_s[j];
    end
  end

  // Outputs are gated by i_rst so they read zero while reset is held.
  assign bus.o_in_ready  = !i_rst && (state_r == IDLE);
  assign bus.o_out_valid = !i_rst && valid_s;
  assign bus.o_out_idx   = (!i_rst && valid_s) ? ibuf_r[0] : {IDX_W{1'b0}};
  assign bus.o_out_last  = !i_rst && valid_s && (cnt_r == 3'd1) && (mask_r == {W{1'b0}});
  assign bus.o_done      = !i_rst && (state_r == DONE);
  assign bus.o_total     = i_rst ? 8'd0 : total_r;
endmodule
